// File: rtl/calc_pkg.sv
// Shared keypad/BCD definitions: key codes, minus marker nibble and entry FSM states.
// Used by keypad_bcd_entry and the downstream BCD-to-sign-magnitude converter.
package calc_pkg;

    localparam logic [3:0] KEY_NEG   = 4'hA;
    localparam logic [3:0] KEY_BKSP  = 4'hB;
    localparam logic [3:0] KEY_CLR   = 4'hC;
    localparam logic [3:0] KEY_ENT   = 4'hD;
    localparam logic [3:0] BCD_MINUS = 4'hE;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ENTRY = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

    function automatic logic is_digit(input logic [3:0] code);
        return code <= 4'd9;
    endfunction

endpackage

// File: rtl/key_edge_detect.sv
// Two-flop rising-edge detector for a raw keypad level; the key code is captured
// alongside the first flop so it lines up with the one-cycle strobe.
module key_edge_detect (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       key_level,
    input  logic [3:0] key_code_in,
    output logic       key_strobe,
    output logic [3:0] key_code_out
);

    logic lvl_q1;
    logic lvl_q2;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            lvl_q1       <= 1'b0;
            lvl_q2       <= 1'b0;
            key_code_out <= '0;
        end else begin
            lvl_q1       <= key_level;
            lvl_q2       <= lvl_q1;
            key_code_out <= key_code_in;
        end
    end

    assign key_strobe = lvl_q1 & ~lvl_q2;

endmodule

// File: rtl/keypad_bcd_entry.sv
// Keypad accumulator producing a signed BCD operand word (minus marker left of MS digit).
// Define KEY_EDGE_EN to accept a raw key_valid level and act only on its rising edge.
module keypad_bcd_entry
    import calc_pkg::*;
#(
    parameter int unsigned DIGITS = 6
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  key_valid,
    input  logic [3:0]            key_code,
    output logic [4*DIGITS-1:0]   bcd_out,
    output logic [2:0]            digit_count,
    output logic                  negative,
    output logic                  entry_done,
    output logic                  key_reject
);

    localparam int unsigned W   = 4 * DIGITS;
    localparam logic [3:0]  CAP = 4'(DIGITS);

    logic         key_fire;
    logic [3:0]   key_sel;

`ifdef KEY_EDGE_EN
    key_edge_detect u_edge (
        .clk          (clk),
        .reset_n      (reset_n),
        .key_level    (key_valid),
        .key_code_in  (key_code),
        .key_strobe   (key_fire),
        .key_code_out (key_sel)
    );
`else
    assign key_fire = key_valid;
    assign key_sel  = key_code;
`endif

    state_t       st_q,   st_n;
    logic [W-1:0] dig_q,  dig_n;
    logic [2:0]   cnt_q,  cnt_n;
    logic         sign_q, sign_n;
    logic         done_n, rej_n;
    logic [W-1:0] bcd_n;
    logic [3:0]   used;
    logic         digit_fits;
    logic         neg_fits;

    // Capacity: digits plus the marker slot must fit in DIGITS nibbles.
    assign used       = {1'b0, cnt_q} + {3'b000, sign_q};
    assign digit_fits = used < CAP;
    assign neg_fits   = sign_q | ({1'b0, cnt_q} < CAP);

    always_comb begin
        st_n   = st_q;
        dig_n  = dig_q;
        cnt_n  = cnt_q;
        sign_n = sign_q;
        done_n = 1'b0;
        rej_n  = 1'b0;
        if (key_fire) begin
            if (is_digit(key_sel)) begin
                if (st_q == ST_DONE) begin
                    dig_n  = W'(key_sel);
                    cnt_n  = (key_sel != 4'd0) ? 3'd1 : 3'd0;
                    sign_n = 1'b0;
                    st_n   = (key_sel != 4'd0) ? ST_ENTRY : ST_EMPTY;
                end else if (cnt_q == 3'd0 && key_sel == 4'd0) begin
                    st_n = st_q;
                end else if (!digit_fits) begin
                    rej_n = 1'b1;
                end else begin
                    dig_n = {dig_q[W-5:0], key_sel};
                    cnt_n = cnt_q + 3'd1;
                    st_n  = ST_ENTRY;
                end
            end else begin
                case (key_sel)
                    KEY_NEG: begin
                        if (!neg_fits) begin
                            rej_n = 1'b1;
                        end else begin
                            sign_n = ~sign_q;
                            if (st_q != ST_DONE)
                                st_n = (cnt_q == 3'd0 && sign_q) ? ST_EMPTY : ST_ENTRY;
                        end
                    end
                    KEY_BKSP: begin
                        if (st_q == ST_DONE) begin
                            dig_n  = '0;
                            cnt_n  = 3'd0;
                            sign_n = 1'b0;
                            st_n   = ST_EMPTY;
                        end else if (cnt_q != 3'd0) begin
                            dig_n = {4'h0, dig_q[W-1:4]};
                            cnt_n = cnt_q - 3'd1;
                            st_n  = (cnt_q == 3'd1 && !sign_q) ? ST_EMPTY : ST_ENTRY;
                        end else begin
                            sign_n = 1'b0;
                            st_n   = ST_EMPTY;
                        end
                    end
                    KEY_CLR: begin
                        dig_n  = '0;
                        cnt_n  = 3'd0;
                        sign_n = 1'b0;
                        st_n   = ST_EMPTY;
                    end
                    KEY_ENT: begin
                        done_n = 1'b1;
                        if (st_q == ST_ENTRY)
                            st_n = ST_DONE;
                    end
                    default: st_n = st_q;
                endcase
            end
        end
    end

    always_comb begin
        bcd_n = dig_n;
        if (sign_n)
            bcd_n = dig_n | (W'(BCD_MINUS) << {cnt_n, 2'b00});
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            st_q       <= ST_EMPTY;
            dig_q      <= '0;
            cnt_q      <= 3'd0;
            sign_q     <= 1'b0;
            bcd_out    <= '0;
            entry_done <= 1'b0;
            key_reject <= 1'b0;
        end else begin
            st_q       <= st_n;
            dig_q      <= dig_n;
            cnt_q      <= cnt_n;
            sign_q     <= sign_n;
            bcd_out    <= bcd_n;
            entry_done <= done_n;
            key_reject <= rej_n;
        end
    end

    assign digit_count = cnt_q;
    assign negative    = sign_q;

endmodule

// File: tb/tb_keypad_bcd_entry.sv
// Directed plus randomized key sequences checked against a digit-list model of the keypad entry.
module tb_keypad_bcd_entry;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        key_valid;
    logic [3:0]  key_code;
    logic [23:0] bcd_out;
    logic [2:0]  digit_count;
    logic        negative;
    logic        entry_done;
    logic        key_reject;

    int tests = 0;
    int fails = 0;

    int digs[$];
    bit msign;
    bit mdn;
    bit mdone;
    bit mrej;

    keypad_bcd_entry #(.DIGITS(6)) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .key_valid   (key_valid),
        .key_code    (key_code),
        .bcd_out     (bcd_out),
        .digit_count (digit_count),
        .negative    (negative),
        .entry_done  (entry_done),
        .key_reject  (key_reject)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic model_clear();
        digs.delete();
        msign = 1'b0;
        mdn   = 1'b0;
    endtask

    task automatic model_key(input int k);
        mdone = 1'b0;
        mrej  = 1'b0;
        if (k <= 9) begin
            if (mdn) begin
                model_clear();
                if (k != 0) digs.push_back(k);
            end else if (digs.size() == 0 && k == 0) begin
                mrej = 1'b0;
            end else if (digs.size() + 1 + int'(msign) > 6) begin
                mrej = 1'b1;
            end else begin
                digs.push_back(k);
            end
        end else if (k == 10) begin
            if (!msign && digs.size() + 1 > 6) mrej = 1'b1;
            else msign = !msign;
        end else if (k == 11) begin
            if (mdn) model_clear();
            else if (digs.size() > 0) void'(digs.pop_back());
            else msign = 1'b0;
        end else if (k == 12) begin
            model_clear();
        end else if (k == 13) begin
            mdone = 1'b1;
            if (digs.size() > 0 || msign || mdn) mdn = 1'b1;
        end
    endtask

    task automatic check(input string tag, input logic [23:0] eb, input logic [2:0] ec,
                         input logic en, input logic ed, input logic er);
        tests++;
        assert (bcd_out === eb) else begin
            fails++; $error("FAIL %s bcd_out got %h expected %h", tag, bcd_out, eb);
        end
        tests++;
        assert (digit_count === ec) else begin
            fails++; $error("FAIL %s digit_count got %0d expected %0d", tag, digit_count, ec);
        end
        tests++;
        assert (negative === en) else begin
            fails++; $error("FAIL %s negative got %b expected %b", tag, negative, en);
        end
        tests++;
        assert (entry_done === ed) else begin
            fails++; $error("FAIL %s entry_done got %b expected %b", tag, entry_done, ed);
        end
        tests++;
        assert (key_reject === er) else begin
            fails++; $error("FAIL %s key_reject got %b expected %b", tag, key_reject, er);
        end
    endtask

    task automatic check_model(input string tag);
        logic [23:0] eb;
        eb = '0;
        foreach (digs[i]) eb = (eb << 4) | 24'(digs[i]);
        if (msign) eb = eb | (24'hE << (4 * digs.size()));
        check(tag, eb, 3'(digs.size()), msign, mdone, mrej);
    endtask

    task automatic expect_bcd(input string tag, input logic [23:0] v);
        tests++;
        assert (bcd_out === v) else begin
            fails++; $error("FAIL %s bcd_out got %h expected %h", tag, bcd_out, v);
        end
    endtask

    task automatic expect_bit(input string tag, input logic got, input logic v);
        tests++;
        assert (got === v) else begin
            fails++; $error("FAIL %s got %b expected %b", tag, got, v);
        end
    endtask

    task automatic press(input logic [3:0] code, input string tag);
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = code;
        @(negedge clk);
        key_valid = 1'b0;
        key_code  = 4'($urandom);
`ifdef KEY_EDGE_EN
        @(negedge clk);
`endif
        model_key(int'(code));
        check_model(tag);
    endtask

    task automatic idle(input string tag);
        @(negedge clk);
        key_code = 4'($urandom);
        mdone = 1'b0;
        mrej  = 1'b0;
        check_model(tag);
    endtask

    initial begin
        reset_n   = 1'b0;
        key_valid = 1'b0;
        key_code  = 4'h0;
        model_clear();
        mdone = 1'b0;
        mrej  = 1'b0;
        repeat (2) @(negedge clk);
        check("reset", 24'h0, 3'd0, 1'b0, 1'b0, 1'b0);
        reset_n = 1'b1;

        press(4'h1, "t1_k1"); press(4'h2, "t1_k2"); press(4'h3, "t1_k3");
        press(4'hD, "t1_ent");
        expect_bcd("t1_value", 24'h000123);
        expect_bit("t1_done_pulse", entry_done, 1'b1);
        idle("t1_after");
        expect_bit("t1_done_single", entry_done, 1'b0);

        press(4'hC, "t2_clr"); press(4'h4, "t2_k4"); press(4'h5, "t2_k5");
        press(4'hA, "t2_neg");
        expect_bcd("t2_neg_value", 24'h000E45);
        expect_bit("t2_negative", negative, 1'b1);
        press(4'hA, "t2_neg2");
        expect_bcd("t2_pos_value", 24'h000045);

        press(4'hC, "t3_clr");
        for (int d = 1; d <= 6; d++) press(4'(d), "t3_fill");
        press(4'h7, "t3_over");
        expect_bit("t3_reject", key_reject, 1'b1);
        expect_bcd("t3_full", 24'h123456);
        press(4'hA, "t3_neg_full");
        expect_bit("t3_neg_reject", key_reject, 1'b1);
        expect_bcd("t3_unchanged", 24'h123456);

        press(4'hC, "t4_clr"); press(4'h0, "t4_z1"); press(4'h0, "t4_z2");
        press(4'h8, "t4_k8");
        expect_bcd("t4_value", 24'h000008);
        press(4'hB, "t4_bksp");
        expect_bcd("t4_empty", 24'h000000);
        press(4'hA, "t4_neg");
        expect_bcd("t4_marker", 24'h00000E);
        press(4'hB, "t4_bksp_sign");
        expect_bit("t4_sign_cleared", negative, 1'b0);

        press(4'h9, "t5_k9"); press(4'hD, "t5_ent"); press(4'h3, "t5_k3");
        expect_bcd("t5_fresh", 24'h000003);
        press(4'hE, "t5_codeE"); press(4'hF, "t5_codeF");
        press(4'hC, "t5_clr");
        expect_bcd("t5_cleared", 24'h000000);
        press(4'hD, "t5_ent_empty");

        press(4'h7, "t6_k7"); press(4'h8, "t6_k8"); press(4'hA, "t6_neg");
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        model_clear();
        mdone = 1'b0;
        mrej  = 1'b0;
        check_model("t6_async_reset");
        @(negedge clk);
        reset_n = 1'b1;
        idle("t6_after_reset");

`ifdef KEY_EDGE_EN
        press(4'h2, "t7_pre");
        @(negedge clk);
        key_valid = 1'b1;
        key_code  = 4'h5;
        repeat (5) @(negedge clk);
        key_valid = 1'b0;
        @(negedge clk);
        model_key(5);
        mdone = 1'b0;
        mrej  = 1'b0;
        check_model("t7_level_hold");
        expect_bcd("t7_one_key", 24'h000025);
`endif

        for (int n = 0; n < 500; n++) begin
            int r;
            logic [3:0] k;
            r = int'($urandom_range(0, 19));
            if (r < 10) k = 4'(r);
            else k = 4'($urandom_range(10, 15));
            press(k, "rand_key");
            if ($urandom_range(0, 7) == 0) idle("rand_idle");
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
